// File: rtl/spi_pkg.sv
// Shared constants and state type for the SPI slave front-end.
package spi_pkg;
   localparam int SPI_BYTE_W          = 8;
   localparam int SPI_SYNC_STAGES_DEF = 2;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } spi_state_t;
endpackage

// File: rtl/spi_sync.sv
// N-flop synchronizer for one asynchronous pin, with a selectable reset level.
module spi_sync #(
   parameter int   N       = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);
   logic [N-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= {N{RST_VAL}};
      else        sync_q <= {sync_q[N-2:0], d_i};
   end

   assign q_o = sync_q[N-1];
endmodule

// File: rtl/spi_bridge.sv
// SPI mode-0 slave: oversamples the pins in the clk domain, delivers MOSI bytes
// with a byte_sync pulse and shifts the decoder's data_out byte back on MISO.
module spi_bridge
   import spi_pkg::*;
#(
   parameter int SYNC_STAGES = SPI_SYNC_STAGES_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sclk,
   input  logic                  cs_n,
   input  logic                  mosi,
   output logic                  miso,
   output logic                  byte_sync,
   output logic [SPI_BYTE_W-1:0] data_in,
   input  logic [SPI_BYTE_W-1:0] data_out,
   output spi_state_t            dbg_state
);
   logic sclk_s, cs_s, mosi_s;

   spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst_n(rst_n), .d_i(sclk), .q_o(sclk_s));
   spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk(clk), .rst_n(rst_n), .d_i(cs_n), .q_o(cs_s));
   spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .rst_n(rst_n), .d_i(mosi), .q_o(mosi_s));

   // Strobes are registered, giving SYNC_STAGES + 1 cycles from pin to strobe.
   logic sclk_q, cs_q;
   logic rise_q, fall_q, cs_fall_q, cs_rise_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_q    <= 1'b0;
         cs_q      <= 1'b1;
         rise_q    <= 1'b0;
         fall_q    <= 1'b0;
         cs_fall_q <= 1'b0;
         cs_rise_q <= 1'b0;
      end else begin
         sclk_q    <= sclk_s;
         cs_q      <= cs_s;
         rise_q    <= sclk_s & ~sclk_q;
         fall_q    <= ~sclk_s & sclk_q;
         cs_fall_q <= ~cs_s & cs_q;
         cs_rise_q <= cs_s & ~cs_q;
      end
   end

   spi_state_t            state_q, state_d;
   logic [2:0]            cnt_q, cnt_d;
   logic [SPI_BYTE_W-1:0] rx_q, rx_d;
   logic [SPI_BYTE_W-1:0] tx_q, tx_d;
   logic [SPI_BYTE_W-1:0] data_in_q, data_in_d;
   logic                  sync_q, sync_d;
   logic                  flag_q, flag_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rx_q      <= '0;
         tx_q      <= '0;
         data_in_q <= '0;
         sync_q    <= 1'b0;
         flag_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rx_q      <= rx_d;
         tx_q      <= tx_d;
         data_in_q <= data_in_d;
         sync_q    <= sync_d;
         flag_q    <= flag_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rx_d      = rx_q;
      tx_d      = tx_q;
      data_in_d = data_in_q;
      sync_d    = 1'b0;
      flag_d    = flag_q;
      case (state_q)
         IDLE: begin
            cnt_d  = '0;
            flag_d = 1'b0;
            if (cs_fall_q) begin
               tx_d    = data_out;
               state_d = ACTIVE;
            end
         end
         ACTIVE: begin
            // Deselect wins over a coincident rise: the partial bit is dropped.
            if (cs_rise_q) begin
               state_d = IDLE;
               cnt_d   = '0;
               flag_d  = 1'b0;
            end else if (rise_q) begin
               rx_d  = {rx_q[SPI_BYTE_W-2:0], mosi_s};
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  data_in_d = {rx_q[SPI_BYTE_W-2:0], mosi_s};
                  sync_d    = 1'b1;
                  flag_d    = 1'b1;
               end
            end else if (fall_q) begin
               // The boundary fall reloads, giving the decoder time after byte_sync.
               if (flag_q) begin
                  tx_d   = data_out;
                  flag_d = 1'b0;
               end else begin
                  tx_d = {tx_q[SPI_BYTE_W-2:0], 1'b0};
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign miso      = (state_q == ACTIVE) ? tx_q[SPI_BYTE_W-1] : 1'b0;
   assign byte_sync = sync_q;
   assign data_in   = data_in_q;
   assign dbg_state = state_q;
endmodule

// File: tb/tb_spi_bridge.sv
// Self-checking bench for spi_bridge: bit-banged SPI master, byte_sync monitor, scoreboard.
module tb_spi_bridge;
   import spi_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n, sclk, cs_n, mosi;
   logic       miso, byte_sync;
   logic [7:0] data_in, data_out;
   spi_state_t dbg_state;

   spi_bridge #(.SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
      .miso(miso), .byte_sync(byte_sync), .data_in(data_in),
      .data_out(data_out), .dbg_state(dbg_state));

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int half  = 8;
   logic [7:0] exp_q[$];

   // Monitor: records every byte_sync with its data and cycle stamp.
   int         cyc = 0;
   int         obs_wr = 0;
   int         rd_ptr = 0;
   int         width_err = 0;
   logic       prev_sync = 1'b0;
   logic [7:0] obs_data[256];
   int         obs_cyc[256];

   always @(negedge clk) begin
      cyc       <= cyc + 1;
      prev_sync <= byte_sync;
      if (byte_sync === 1'b1) begin
         obs_data[obs_wr % 256] <= data_in;
         obs_cyc[obs_wr % 256]  <= cyc;
         obs_wr                 <= obs_wr + 1;
         if (prev_sync === 1'b1) width_err <= width_err + 1;
      end
   end

   task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] r);
      r = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         mosi = b[i];
         repeat (half) @(negedge clk);
         sclk = 1'b1;
         r[i] = miso;
         repeat (half) @(negedge clk);
         sclk = 1'b0;
      end
   endtask

   task automatic cs_begin();
      cs_n = 1'b0;
      repeat (half) @(negedge clk);
   endtask

   task automatic cs_end();
      repeat (half) @(negedge clk);
      cs_n = 1'b1;
      repeat (10 + $urandom_range(0, 6)) @(negedge clk);
   endtask

   task automatic scoreboard_drain(input string name);
      logic [7:0] e;
      n_vec++;
      if (obs_wr - rd_ptr != exp_q.size()) begin
         n_err++;
         $display("FAIL %s pulse_count got=%0d exp=%0d", name, obs_wr - rd_ptr, exp_q.size());
      end
      while (exp_q.size() > 0 && rd_ptr < obs_wr) begin
         e = exp_q.pop_front();
         n_vec++;
         if (obs_data[rd_ptr % 256] !== e) begin
            n_err++;
            $display("FAIL %s data_in got=%02h exp=%02h", name, obs_data[rd_ptr % 256], e);
         end
         rd_ptr++;
      end
      exp_q.delete();
      rd_ptr = obs_wr;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; data_out = 8'h00;
      repeat (3) @(negedge clk);
      n_vec += 4;
      if (miso !== 1'b0)      begin n_err++; $display("FAIL reset miso got=%b exp=0", miso); end
      if (byte_sync !== 1'b0) begin n_err++; $display("FAIL reset byte_sync got=%b exp=0", byte_sync); end
      if (data_in !== 8'h00)  begin n_err++; $display("FAIL reset data_in got=%02h exp=00", data_in); end
      if (dbg_state !== IDLE) begin n_err++; $display("FAIL reset state got=%0d exp=IDLE", dbg_state); end
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_write();
      logic [7:0] r0, r1;
      cs_begin();
      exp_q.push_back(8'h81); spi_bits(8'h81, 8, r0);
      exp_q.push_back(8'hA5); spi_bits(8'hA5, 8, r1);
      cs_end();
      n_vec += 2;
      if (r0 !== 8'h00) begin n_err++; $display("FAIL write miso0 got=%02h exp=00", r0); end
      if (r1 !== 8'h00) begin n_err++; $display("FAIL write miso1 got=%02h exp=00", r1); end
      scoreboard_drain("write");
   endtask

   task automatic test_read(input string name);
      logic [7:0] r0, r1;
      bit got = 1'b0;
      data_out = 8'h00;
      cs_begin();
      exp_q.push_back(8'h02);
      exp_q.push_back(8'h00);
      fork
         begin
            spi_bits(8'h02, 8, r0);
            spi_bits(8'h00, 8, r1);
         end
         begin
            for (int k = 0; k < 2000 && !got; k++) begin
               @(negedge clk);
               if (byte_sync === 1'b1) got = 1'b1;
            end
            if (got) begin
               @(negedge clk);
               data_out = 8'h3C;
            end
         end
      join
      cs_end();
      data_out = 8'h00;
      n_vec += 3;
      if (!got)         begin n_err++; $display("FAIL %s sync_timeout got=0 exp=1", name); end
      if (r0 !== 8'h00) begin n_err++; $display("FAIL %s miso0 got=%02h exp=00", name, r0); end
      if (r1 !== 8'h3C) begin n_err++; $display("FAIL %s miso1 got=%02h exp=3c", name, r1); end
      scoreboard_drain(name);
   endtask

   task automatic test_abort();
      logic [7:0] r;
      cs_begin();
      spi_bits(8'hFF, 5, r);
      cs_end();
      scoreboard_drain("abort_partial");
      cs_begin();
      exp_q.push_back(8'h55); spi_bits(8'h55, 8, r);
      cs_end();
      scoreboard_drain("abort_next");
   endtask

   task automatic test_back_to_back();
      logic [7:0] r;
      int base;
      base = obs_wr;
      cs_begin();
      exp_q.push_back(8'h11); spi_bits(8'h11, 8, r);
      exp_q.push_back(8'h22); spi_bits(8'h22, 8, r);
      exp_q.push_back(8'h33); spi_bits(8'h33, 8, r);
      cs_end();
      for (int i = 0; i < 2; i++) begin
         n_vec++;
         if (obs_wr > base + i + 1 &&
             obs_cyc[(base + i + 1) % 256] - obs_cyc[(base + i) % 256] !== 16 * half) begin
            n_err++;
            $display("FAIL stream spacing%0d got=%0d exp=%0d", i,
                     obs_cyc[(base + i + 1) % 256] - obs_cyc[(base + i) % 256], 16 * half);
         end
      end
      scoreboard_drain("stream");
   endtask

   task automatic test_reset_mid_byte();
      logic [7:0] r;
      data_out = 8'hFF;
      cs_begin();
      spi_bits(8'hC3, 4, r);
      rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0;
      @(negedge clk);
      n_vec += 4;
      if (data_in !== 8'h00)  begin n_err++; $display("FAIL rstmid data_in got=%02h exp=00", data_in); end
      if (miso !== 1'b0)      begin n_err++; $display("FAIL rstmid miso got=%b exp=0", miso); end
      if (byte_sync !== 1'b0) begin n_err++; $display("FAIL rstmid byte_sync got=%b exp=0", byte_sync); end
      if (dbg_state !== IDLE) begin n_err++; $display("FAIL rstmid state got=%0d exp=IDLE", dbg_state); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      data_out = 8'h00;
      repeat (6) @(negedge clk);
      scoreboard_drain("rstmid_none");
      cs_begin();
      exp_q.push_back(8'hC3); spi_bits(8'hC3, 8, r);
      cs_end();
      scoreboard_drain("rstmid_after");
   endtask

   initial begin
      test_reset();
      test_write();
      test_read("read");
      test_abort();
      test_back_to_back();
      test_reset_mid_byte();
      half = 4;
      test_read("slow_read");
      n_vec++;
      if (width_err != 0) begin n_err++; $display("FAIL sync_width got=%0d exp=0", width_err); end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/spi_bridge.md
# spi_bridge

SPI slave front-end of the PWM peripheral, sitting directly upstream of the instruction decoder. It oversamples the external SPI pins (mode 0, MSB first, 8-bit frames) in the `clk` domain and assembles MOSI bytes. Each received byte is presented to the decoder on `data_in` with a one-cycle `byte_sync` pulse. The byte the decoder drives on `data_out` is shifted back out on MISO during the next byte slot.

## Interface
- `SYNC_STAGES`, default 2: flip-flop depth of the input synchronizers on `sclk`, `cs_n` and `mosi`. Minimum 2.
- `clk`  in  1: peripheral clock. Must run at ≥ 8× the `sclk` frequency.
- `rst_n`  in  1: reset. Asynchronous, active-low.
- `sclk`  in  1: SPI clock from the master, asynchronous to `clk`. Idles low.
- `cs_n`  in  1: SPI chip select, active-low, asynchronous.
- `mosi`  in  1: master-out serial data, asynchronous.
- `miso`  out  1: slave-out serial data. Driven 0 while deselected; no tri-state.
- `byte_sync`  out  1: one-`clk` pulse; marks a complete received byte.
- `data_in`  out  8: last received byte. Held until the next `byte_sync`.
- `data_out`  in  8: byte to transmit. Sampled at byte-slot start.

## Operation
- Synchronizers: all three pins pass through `SYNC_STAGES` flops. An edge detector on synchronized `sclk`/`cs_n` produces single-cycle `rise`, `fall`, `cs_fall`, `cs_rise` strobes.
- State `IDLE` (`cs_n` high):
  - Bit counter = 0, shift registers hold, `miso` = 0.
  - On `cs_fall`: load `tx_shift` ← `data_out` and enter `ACTIVE`.
- State `ACTIVE`, on `rise`:
  - `rx_shift` ← {`rx_shift[6:0]`, `mosi_s`}.
  - Bit counter increments, wrapping 7 → 0.
  - When the counter was 7: `data_in` ← {`rx_shift[6:0]`, `mosi_s`}, `byte_sync` ← 1, and a byte-boundary flag is set.
- State `ACTIVE`, on `fall`:
  - If the byte-boundary flag is set: `tx_shift` ← `data_out`, clear the flag. This gives the decoder time to respond to the preceding `byte_sync`.
  - Otherwise: `tx_shift` ← {`tx_shift[6:0]`, 0}.
- `miso` = `tx_shift[7]` whenever in `ACTIVE`.
- On `cs_rise`, from any point:
  - Return to `IDLE` and discard any partial byte; no `byte_sync` is issued.
  - Clear the counter and the flag.
- Multi-byte frames: the counter wraps and bytes stream back-to-back with no gap. Each byte gets its own `byte_sync`.
- Simultaneous `cs_rise` and `rise` in the same cycle: `cs_rise` wins and the bit is dropped.

## Timing
- Reset values:
  - Outputs: `miso` = 0, `byte_sync` = 0, `data_in` = 0x00.
  - Internal: `rx_shift`, `tx_shift`, counter, flag all 0; state `IDLE`.
- Reset asserted mid-byte clears everything immediately. The partial byte is lost, and after reset the block waits for a fresh `cs_fall`.
- Edge-detect latency: `SYNC_STAGES` + 1 `clk` cycles from the pin edge to the strobe.
- `byte_sync` rises on the `clk` edge after the 8th `rise` strobe and is high for exactly 1 cycle. `data_in` updates on that same edge.
- `data_out` must be stable by the boundary `fall` strobe. With `clk` ≥ 8× `sclk`, this is ≥ 3 `clk` cycles after `byte_sync`, which covers the decoder's one-cycle registered read path.
- `miso` changes 1 `clk` after a `fall` strobe or `cs_fall`. The master samples it on the next `sclk` rising edge.

## Structure
- Shared package `spi_pkg`:
  - `SPI_BYTE_W` = 8.
  - `SPI_SYNC_STAGES_DEF` = 2.
  - State enum `spi_state_t` {`IDLE`, `ACTIVE`}.
- Sub-module `spi_sync`: parameterized N-flop synchronizer with reset value as a parameter, instanced 3×. `cs_n` resets to 1; the others reset to 0.
- Edge detection, counter, shift registers and FSM live in `spi_bridge` itself.

## Test plan
- Write frame: `cs_n` low, MOSI 0x81 then 0xA5 → two `byte_sync` pulses, with `data_in` = 0x81 then 0xA5; `miso` = 0 throughout, since `data_out` = 0x00.
- Read frame: MOSI 0x02, bench drives `data_out` = 0x3C one cycle after the first `byte_sync` → `miso` emits 0,0,1,1,1,1,0,0 on the 2nd byte's rising edges.
- Abort: `cs_n` rises after 5 bits of 0xFF → no `byte_sync`. The next frame's 0x55 gives `data_in` = 0x55 with exactly one pulse.
- Streaming: 3 bytes 0x11/0x22/0x33 in one `cs_n` window → 3 pulses spaced exactly 8 `sclk` periods apart, with correct values.
- Reset mid-byte: `rst_n` low after bit 4 → `data_in` = 0x00, `miso` = 0, `byte_sync` = 0. A subsequent full frame with 0xC3 decodes correctly.
- Slow-clock limit: `clk` = 8× `sclk`, read frame as above → `miso` byte is still 0x3C. This checks the `data_out` setup margin.
